// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// optional first-word-fall-through read, synchronous flush and sticky error flags.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int AF_THRESH  = 56,
  parameter int AE_THRESH  = 8,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AF_C    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AE_C    = AE_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_acc, rd_acc;

  // All status flags come from the registered count, never from this cycle's inputs.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    rvalid_d = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    // Clear first so a same-cycle set wins.
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_en && full && !flush)  ovf_d = 1'b1;
    if (rd_en && empty && !flush) unf_d = 1'b1;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PTR_ONE;
      if (rd_acc) begin
        rptr_d   = rptr_q + PTR_ONE;
        dout_d   = mem[rptr_q];
        rvalid_d = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !flush) mem[wptr_q] <= data_in;
  end

  // FWFT presents the head word combinationally; it reads as zero while empty.
  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem[rptr_q];
      assign rd_valid = ~empty;
    end else begin : g_std
      assign data_out = dout_q;
      assign rd_valid = rvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: standard and FWFT instances share one stimulus stream
// and are compared every cycle against a queue-based model plus literal spot values.
module tb_sync_fifo_flags;

  localparam int DEPTH = 64;
  localparam int AF    = 56;
  localparam int AE    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [7:0] data_in = '0;

  logic [7:0] data_s, data_f;
  logic [6:0] count_s, count_f;
  logic       rv_s, full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic       rv_f, full_f, empty_f, af_f, ae_f, ovf_f, unf_f;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] m_dout = '0;
  logic       m_rv = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  sync_fifo_flags #(.FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_s), .rd_valid(rv_s), .flush(flush), .clr_err(clr_err),
    .count(count_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
    .almost_empty(ae_s), .overflow(ovf_s), .underflow(unf_s)
  );

  sync_fifo_flags #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_f), .rd_valid(rv_f), .flush(flush), .clr_err(clr_err),
    .count(count_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .overflow(ovf_f), .underflow(unf_f)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog act=timeout exp=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Model: FIFO contents as a queue; flags follow directly from its size.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_dout = '0;
      m_rv   = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      automatic bit was_full  = (exp_q.size() == DEPTH);
      automatic bit was_empty = (exp_q.size() == 0);
      if (clr_err) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (!flush && wr_en && was_full)  m_ovf = 1'b1;
      if (!flush && rd_en && was_empty) m_unf = 1'b1;
      if (flush) begin
        exp_q.delete();
        m_rv = 1'b0;
      end else begin
        m_rv = rd_en && !was_empty;
        if (m_rv) m_dout = exp_q.pop_front();
        if (wr_en && !was_full) exp_q.push_back(data_in);
      end
    end
  end

  task automatic cmp_flags(input string tag, input logic [6:0] c, input logic f, input logic e,
                           input logic a_f, input logic a_e, input logic o, input logic u);
    automatic int n = exp_q.size();
    chk({"count_", tag}, 32'(c), 32'(n));
    chk({"full_", tag}, 32'(f), 32'(n == DEPTH));
    chk({"empty_", tag}, 32'(e), 32'(n == 0));
    chk({"afull_", tag}, 32'(a_f), 32'(n >= AF));
    chk({"aempty_", tag}, 32'(a_e), 32'(n <= AE));
    chk({"ovf_", tag}, 32'(o), 32'(m_ovf));
    chk({"unf_", tag}, 32'(u), 32'(m_unf));
  endtask

  // Compare process: outputs are purely registered, so mid-low-phase sampling is stable.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      cmp_flags("s", count_s, full_s, empty_s, af_s, ae_s, ovf_s, unf_s);
      cmp_flags("f", count_f, full_f, empty_f, af_f, ae_f, ovf_f, unf_f);
      chk("dout_s", 32'(data_s), 32'(m_dout));
      chk("rv_s", 32'(rv_s), 32'(m_rv));
      chk("dout_f", 32'(data_f), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
      chk("rv_f", 32'(rv_f), 32'(exp_q.size() > 0));
    end
  end

  // Driver: called at a negedge, applies one cycle of inputs, returns at the next negedge.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic f = 1'b0, input logic c = 1'b0);
    wr_en = w; data_in = d; rd_en = r; flush = f; clr_err = c;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count_s), 32'd0);
    chk("rst_empty", 32'(empty_s), 32'd1);
    chk("rst_ae", 32'(ae_s), 32'd1);
    chk("rst_af", 32'(af_s), 32'd0);
    chk("rst_rv_f", 32'(rv_f), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // Fill 0x00..0x3F, threshold crossings, overflow, drain
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 7)  chk("ae_at8", 32'(ae_s), 32'd1);
      if (i == 8)  chk("ae_at9", 32'(ae_s), 32'd0);
      if (i == 54) chk("af_at55", 32'(af_s), 32'd0);
      if (i == 55) chk("af_at56", 32'(af_s), 32'd1);
      if (i == 62) chk("full_at63", 32'(full_s), 32'd0);
    end
    chk("full_at64", 32'(full_s), 32'd1);
    step(1'b1, 8'hEE, 1'b0);
    chk("ovf_65th", 32'(ovf_s), 32'd1);
    chk("cnt_65th", 32'(count_s), 32'd64);
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (i == 1) chk("rd_word1", 32'(data_s), 32'h01);
    end
    chk("rd_last", 32'(data_s), 32'h3F);
    chk("drain_empty", 32'(empty_s), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(ovf_s), 32'd0);

    // Pointer wrap: 40 in / 40 out, twice
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
      for (int i = 0; i < 40; i++) begin
        step(1'b0, 8'h00, 1'b1);
        if (i == 39) chk("wrap_last", 32'(data_s), 32'hA7);
      end
    end
    chk("wrap_cnt", 32'(count_s), 32'd0);
    chk("wrap_ovf", 32'(ovf_s), 32'd0);
    chk("wrap_unf", 32'(unf_s), 32'd0);

    // Simultaneous read+write at full and at empty
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i) ^ 8'h55, 1'b0);
    step(1'b1, 8'h11, 1'b1);
    chk("full_rw_cnt", 32'(count_s), 32'd63);
    chk("full_rw_ovf", 32'(ovf_s), 32'd1);
    chk("full_rw_dout", 32'(data_s), 32'h55);
    for (int i = 0; i < 63; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h5C, 1'b1);
    chk("empty_rw_cnt", 32'(count_s), 32'd1);
    chk("empty_rw_unf", 32'(unf_s), 32'd1);
    chk("empty_rw_fwft", 32'(data_f), 32'h5C);
    step(1'b0, 8'h00, 1'b1);
    chk("empty_rw_read", 32'(data_s), 32'h5C);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // FWFT fall-through of a single word
    step(1'b1, 8'hA5, 1'b0);
    chk("fwft_empty", 32'(empty_f), 32'd0);
    chk("fwft_dout", 32'(data_f), 32'hA5);
    step(1'b0, 8'h00, 1'b1);
    chk("fwft_pop_empty", 32'(empty_f), 32'd1);

    // Flush, then set-beats-clear on overflow
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    chk("flush_cnt", 32'(count_s), 32'd0);
    chk("flush_empty", 32'(empty_s), 32'd1);
    chk("flush_rv", 32'(rv_s), 32'd0);
    chk("flush_dout_hold", 32'(data_s), 32'hA5);
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i * 3), 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
    chk("set_beats_clr", 32'(ovf_s), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_alone", 32'(ovf_s), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset mid-burst at count 10
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    cmp_en = 1'b0;
    wr_en = 1'b1; data_in = 8'h99;
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(count_s), 32'd0);
    chk("arst_empty", 32'(empty_s), 32'd1);
    chk("arst_dout_s", 32'(data_s), 32'd0);
    chk("arst_dout_f", 32'(data_f), 32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    step(1'b1, 8'h42, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_rd", 32'(data_s), 32'h42);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
